// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle between the timing generator (master) and its pixel source / HDMI transmitter (slave).
interface video_timing_gen_if;
  logic        enable;
  logic [35:0] pix_in;
  logic        pix_req;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [35:0] d;
  logic        frame_start;

  modport master (
    input  enable, pix_in,
    output pix_req, de, hsync, vsync, d, frame_start
  );

  modport slave (
    output enable, pix_in,
    input  pix_req, de, hsync, vsync, d, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Two-stage raster timing generator for an SII9136 transmitter (pix_req one cycle ahead of de).
// Define VTG_TEST_PATTERN_EN to replace pix_in with eight vertical colour bars.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               reset_,
  video_timing_gen_if.master vid
);

  localparam int DATA_W  = 36;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ONE  = VW'(1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic              pix_req_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic              fs_p1;
  logic              de_p2;
  logic              hs_p2;
  logic              vs_p2;
  logic              fs_p2;
  logic [DATA_W-1:0] d_p2;
  logic [DATA_W-1:0] src;

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

  logic [DATA_W-1:0] pat_p1;

  // Bar index bits map directly onto the colour order white..black.
  function automatic logic [DATA_W-1:0] bar_colour(input logic [HW-1:0] x);
    logic [2:0] idx;
    idx = 3'(x / BAR_W);
    return {{12{~idx[1]}}, {12{~idx[2]}}, {12{~idx[0]}}};
  endfunction

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pat_p1 <= '0;
    end else if (!vid.enable) begin
      pat_p1 <= '0;
    end else begin
      pat_p1 <= bar_colour(h);
    end
  end

  assign src = pat_p1;
`else
  assign src = vid.pix_in;
`endif

  // Stage 1: raster counters and per-position decode.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      h          <= '0;
      v          <= '0;
      pix_req_p1 <= 1'b0;
      hs_p1      <= ~HS_POL;
      vs_p1      <= ~VS_POL;
      fs_p1      <= 1'b0;
    end else if (!vid.enable) begin
      h          <= '0;
      v          <= '0;
      pix_req_p1 <= 1'b0;
      hs_p1      <= ~HS_POL;
      vs_p1      <= ~VS_POL;
      fs_p1      <= 1'b0;
    end else begin
      pix_req_p1 <= (h < H_ACT) && (v < V_ACT);
      hs_p1      <= ((h >= HS_BEG) && (h < HS_END)) ? HS_POL : ~HS_POL;
      vs_p1      <= ((v >= VS_BEG) && (v < VS_END)) ? VS_POL : ~VS_POL;
      fs_p1      <= (h == '0) && (v == '0);
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + V_ONE;
      end else begin
        h <= h + H_ONE;
      end
    end
  end

  // Stage 2: output registers; pixel data is captured at the end of the pix_req cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      de_p2 <= 1'b0;
      hs_p2 <= ~HS_POL;
      vs_p2 <= ~VS_POL;
      fs_p2 <= 1'b0;
      d_p2  <= '0;
    end else begin
      de_p2 <= pix_req_p1;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
      fs_p2 <= fs_p1;
      d_p2  <= pix_req_p1 ? src : '0;
    end
  end

  assign vid.pix_req     = pix_req_p1;
  assign vid.de          = de_p2;
  assign vid.hsync       = hs_p2;
  assign vid.vsync       = vs_p2;
  assign vid.frame_start = fs_p2;
  assign vid.d           = d_p2;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (25x10), with a per-cycle scoreboard plus directed timing checks.
module tb_video_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSY = 4;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b0;

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [35:0] pat;
  } st1_t;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  logic [40:0] exp_q[$];
  logic [35:0] bars[8] = '{36'hFFF_FFF_FFF, 36'hFFF_FFF_000, 36'h000_FFF_FFF, 36'h000_FFF_000,
                           36'hFFF_000_FFF, 36'hFFF_000_000, 36'h000_000_FFF, 36'h000_000_000};

  video_timing_gen_if vif();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clk   (clk),
    .reset_(reset_),
    .vid   (vif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic st1_t idle1();
    st1_t s;
    s.act = 1'b0;
    s.hs  = ~HSP;
    s.vs  = ~VSP;
    s.fs  = 1'b0;
    s.pat = 36'h0;
    return s;
  endfunction

  // Expected stage-1 content for the p-th consecutive enabled edge.
  function automatic st1_t stage1_at(input int p);
    st1_t s;
    int   h;
    int   v;
    h     = p % HT;
    v     = (p / HT) % VT;
    s.act = (h < HA) && (v < VA);
    s.hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
    s.vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
    s.fs  = (h == 0) && (v == 0);
    s.pat = bars[(h / (HA / 8)) % 8];
    return s;
  endfunction

  st1_t m1 = '{1'b0, ~HSP, ~VSP, 1'b0, 36'h0};
  int   t  = 0;

  // Reference model: pushes the outputs expected after each edge.
  always @(posedge clk or negedge reset_) begin : model
    logic [35:0] ed;
    st1_t        prev;
    if (!reset_) begin
      t  = 0;
      m1 = idle1();
      exp_q.delete();
      exp_q.push_back({1'b0, 1'b0, ~HSP, ~VSP, 1'b0, 36'h0});
    end else begin
      prev = m1;
`ifdef VTG_TEST_PATTERN_EN
      ed = prev.act ? prev.pat : 36'h0;
`else
      ed = prev.act ? vif.pix_in : 36'h0;
`endif
      if (vif.enable) begin
        m1 = stage1_at(t);
        t++;
      end else begin
        m1 = idle1();
        t  = 0;
      end
      exp_q.push_back({m1.act, prev.act, prev.hs, prev.vs, prev.fs, ed});
    end
  end

  always @(negedge clk) begin : monitor
    logic [40:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard",
            64'({vif.pix_req, vif.de, vif.hsync, vif.vsync, vif.frame_start, vif.d}),
            64'(e));
    end
  end

  task automatic tick();
    @(negedge clk);
    vif.pix_in = 36'({$urandom(), $urandom()});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    vif.enable = 1'b0;
    vif.pix_in = 36'h0;
    reset_     = 1'b0;
    repeat (3) tick();
    check("rst_pix_req", 64'(vif.pix_req), 64'(0));
    check("rst_de",      64'(vif.de), 64'(0));
    check("rst_d",       64'(vif.d), 64'(0));
    check("rst_hsync",   64'(vif.hsync), 64'(1));
    check("rst_vsync",   64'(vif.vsync), 64'(1));
    check("rst_fs",      64'(vif.frame_start), 64'(0));

    reset_ = 1'b1;
    tick();
    vif.enable = 1'b1;
    tick();
    check("first_pix_req", 64'(vif.pix_req), 64'(1));
    check("first_de_early", 64'(vif.de), 64'(0));
    tick();
    check("first_de", 64'(vif.de), 64'(1));
    check("first_fs", 64'(vif.frame_start), 64'(1));
    c0 = cyc;

    n = 0;
    while (vif.de === 1'b1 && n < 100) begin n++; tick(); end
    check("de_per_line", 64'(n), 64'(HA));
    n = 0;
    while (vif.hsync === 1'b1 && n < 100) begin n++; tick(); end
    check("hsync_delay", 64'(n), 64'(HFP));
    n = 0;
    while (vif.hsync === 1'b0 && n < 100) begin n++; tick(); end
    check("hsync_width", 64'(n), 64'(HSY));
    n = 0;
    while (vif.de !== 1'b1 && n < 100) begin n++; tick(); end
    check("line_period", 64'(cyc - c0), 64'(HT));

    n = 0;
    while (vif.frame_start !== 1'b1 && n < 1000) begin n++; tick(); end
    check("fs_wait", 64'(n < 1000), 64'(1));
    for (int f = 0; f < 2; f++) begin
      int   vs_lo;
      int   lines;
      logic de_q;
      c0    = cyc;
      vs_lo = 0;
      lines = 1;
      de_q  = 1'b1;
      n     = 0;
      tick();
      while (vif.frame_start !== 1'b1 && n < 1000) begin
        if (vif.vsync === 1'b0) vs_lo++;
        if (vif.de === 1'b1 && de_q !== 1'b1) lines++;
        de_q = vif.de;
        n++;
        tick();
      end
      check("vsync_low_cycles", 64'(vs_lo), 64'(VSY * HT));
      check("frame_period", 64'(cyc - c0), 64'(HT * VT));
      check("de_lines", 64'(lines), 64'(VA));
    end

    // At a frame_start sample the counter already sits at position 2.
    repeat (3 * HT + 10 - 2) tick();
    vif.enable = 1'b0;
    tick();
    check("abort_pix_req", 64'(vif.pix_req), 64'(0));
    check("abort_de_lag", 64'(vif.de), 64'(1));
    tick();
    check("abort_de",    64'(vif.de), 64'(0));
    check("abort_d",     64'(vif.d), 64'(0));
    check("abort_hsync", 64'(vif.hsync), 64'(1));
    check("abort_vsync", 64'(vif.vsync), 64'(1));
    check("abort_fs",    64'(vif.frame_start), 64'(0));
    repeat (3) tick();
    vif.enable = 1'b1;
    tick();
    check("reen_pix_req", 64'(vif.pix_req), 64'(1));
    check("reen_fs_early", 64'(vif.frame_start), 64'(0));
    tick();
    check("reen_fs", 64'(vif.frame_start), 64'(1));

`ifdef VTG_TEST_PATTERN_EN
    check("bar_x0", 64'(vif.d), 64'(36'hFFF_FFF_FFF));
    repeat (2) tick();
    check("bar_x2", 64'(vif.d), 64'(36'hFFF_FFF_000));
    repeat (13) tick();
    check("bar_x15", 64'(vif.d), 64'(36'h0));
    check("bar_x15_de", 64'(vif.de), 64'(1));
`else
    check("pass_req", 64'(vif.pix_req), 64'(1));
    vif.pix_in = 36'hABC_123_456;
    tick();
    check("pass_d", 64'(vif.d), 64'(36'hABC_123_456));
    check("pass_de", 64'(vif.de), 64'(1));
`endif

    repeat (3) tick();
    @(posedge clk);
    #2 reset_ = 1'b0;
    #1;
    check("midrst_pix_req", 64'(vif.pix_req), 64'(0));
    check("midrst_de",      64'(vif.de), 64'(0));
    check("midrst_d",       64'(vif.d), 64'(0));
    check("midrst_hsync",   64'(vif.hsync), 64'(1));
    check("midrst_vsync",   64'(vif.vsync), 64'(1));
    repeat (3) tick();
    reset_ = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  H_ACTIVE  640  active pixels per line
  H_FP  16  horizontal front porch, pixels
  H_SYNC  96  hsync width, pixels
  H_BP  48  horizontal back porch, pixels
  V_ACTIVE  480  active lines per frame
  V_FP  10  vertical front porch, lines
  V_SYNC  2  vsync width, lines
  V_BP  33  vertical back porch, lines
  HS_POL  0  hsync active level
  VS_POL  0  vsync active level
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  pixel clock, 25 MHz oscillator domain
  reset_  in  1  reset; asynchronous, active-low
  enable  in  1  run timing; low holds the generator idle at frame start
  pix_in  in  36  pixel {R[35:24],G[23:12],B[11:0]}, sampled when pix_req=1
  pix_req  out  1  pixel request, one cycle ahead of de
  de  out  1  data enable to SII9136
  hsync  out  1  horizontal sync to SII9136
  vsync  out  1  vertical sync to SII9136
  d  out  36  pixel data to SII9136
  frame_start  out  1  one-cycle pulse with de of pixel (0,0)

Function
REQ-003 Horizontal counter h SHALL count 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default), advancing once per clk while enable=1.
REQ-004 Vertical counter v SHALL count 0..V_TOTAL-1, where V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default), advancing when h wraps; v SHALL wrap to 0 after V_TOTAL-1.
REQ-005 Line order SHALL be active, front porch, sync, back porch; the frame order SHALL be the same.
REQ-006 All outputs SHALL be registered.
REQ-007 Stage 1: pix_req SHALL be 1 for the cycle after an edge where enable=1, h<H_ACTIVE and v<V_ACTIVE.
REQ-008 Stage 2: de, hsync, vsync and d SHALL follow stage 1 by exactly one cycle, so de in cycle N+1 matches pix_req in cycle N.
REQ-009 hsync SHALL equal HS_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, delayed by the two-stage pipeline; otherwise it SHALL equal ~HS_POL.
REQ-010 vsync SHALL equal VS_POL while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for all h of those lines and with the same pipeline delay; otherwise it SHALL equal ~VS_POL.
REQ-011 d SHALL be 0 whenever de=0.
REQ-012 frame_start SHALL pulse exactly once per frame, coincident with de of h=0, v=0.
REQ-013 enable sampled low SHALL reset h and v to 0 and drive pix_req=0 at the same edge; de, d and frame_start SHALL go to 0 and hsync/vsync to their inactive levels at the following edge, including mid-line and mid-frame.
REQ-014 On enable rising, the first edge sampling enable=1 SHALL set pix_req=1 for pixel (0,0), so the first de follows 2 edges after enable is seen high.
REQ-015 The block SHALL apply no backpressure: pix_in SHALL be sampled on every pix_req cycle, unconditionally.

Reset
REQ-016 reset_=0 SHALL asynchronously clear h, v, pix_req, de, d and frame_start, and SHALL set hsync=~HS_POL and vsync=~VS_POL.
REQ-017 After reset_ deasserts, behaviour SHALL be as in REQ-014 once enable=1.

Configuration
REQ-018 With VTG_TEST_PATTERN_EN defined, d SHALL carry 8 vertical colour bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black, with each component 12'hFFF or 12'h000; pix_in SHALL be ignored and pix_req SHALL still toggle.
REQ-019 Without VTG_TEST_PATTERN_EN, d SHALL equal pix_in as sampled in the pix_req cycle, and no pattern logic SHALL be synthesized.

Verification
REQ-020 Reset: assert reset_=0 mid-line -> outputs immediately read de=0, d=0, pix_req=0, hsync=1, vsync=1 (default polarity).
REQ-021 Line timing: enable=1 from reset -> pix_req asserted after 1 edge; 640 de cycles; hsync low 96 cycles starting 16 cycles after de falls; line period 800 cycles.
REQ-022 Frame timing: run 2 frames -> vsync low for exactly 2×800 cycles per frame; frame_start period 420000 cycles; de seen on 480 lines per frame.
REQ-023 Abort: drop enable at h=300, v=100 for 5 cycles -> idle outputs 1 edge later; on re-enable, frame_start occurs 2 edges after enable is seen high.
REQ-024 Passthrough (macro undefined): pix_in=36'hABC_123_456 on a pix_req cycle -> d=36'hABC_123_456 with de=1 on the next cycle.
REQ-025 Pattern (macro defined): pixel x=0 -> d=36'hFFF_FFF_FFF; x=80 -> 36'hFFF_FFF_000; x=639 -> 36'h0.
